// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU 2-entry skid FIFOs, round-robin onto one registered CDB.
// Optional macro CDB_BYPASS_EN lets an empty FIFO's live input compete directly for the bus.
module cdb_arbiter #(
  parameter int NUM_FU     = 3,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]    fu_preg_flat,
  input  logic [NUM_FU*DATA_W-1:0]   fu_value_flat,
  input  logic [NUM_FU*TAG_W-1:0]    fu_rob_flat,
  input  logic [NUM_FU-1:0]          fu_regwrite,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_preg,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [TAG_W-1:0]           cdb_rob,
  output logic                       cdb_regwrite,
  output logic [1:0]                 cdb_src
);
  localparam int ENT_W = 1 + TAG_W + DATA_W + TAG_W;

  logic [ENT_W-1:0]  mem [NUM_FU][FIFO_DEPTH];
  logic [1:0]        count [NUM_FU];
  logic              wr_ptr [NUM_FU];
  logic              rd_ptr [NUM_FU];
  logic [1:0]        rr_ptr;

  logic [ENT_W-1:0]  in_ent [NUM_FU];
  logic [ENT_W-1:0]  head_ent [NUM_FU];
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_any;
  logic [1:0]        winner;
  logic [ENT_W-1:0]  grant_ent;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_src
    assign in_ent[gi]   = {fu_regwrite[gi], fu_rob_flat[gi*TAG_W +: TAG_W],
                           fu_value_flat[gi*DATA_W +: DATA_W], fu_preg_flat[gi*TAG_W +: TAG_W]};
    assign head_ent[gi] = mem[gi][rd_ptr[gi]];
    assign nonempty[gi] = (count[gi] != 2'd0);
    assign fu_ready[gi] = (count[gi] < 2'(FIFO_DEPTH));
`ifdef CDB_BYPASS_EN
    assign cand[gi]     = nonempty[gi] | fu_valid[gi];
`else
    assign cand[gi]     = nonempty[gi];
`endif
  end

  // First candidate in rr_ptr, rr_ptr+1, rr_ptr+2 (mod NUM_FU) order wins.
  always_comb begin
    logic [2:0] idx;
    grant_any = 1'b0;
    winner    = 2'd0;
    idx       = 3'd0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= 3'(NUM_FU)) idx = idx - 3'(NUM_FU);
      if (!grant_any && cand[idx[1:0]]) begin
        grant_any = 1'b1;
        winner    = idx[1:0];
      end
    end
  end

  always_comb begin
    grant_ent = head_ent[winner];
`ifdef CDB_BYPASS_EN
    if (!nonempty[winner]) grant_ent = in_ent[winner];
`endif
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]  = grant_any && (winner == 2'(i)) && nonempty[i];
      push[i] = fu_valid[i] && fu_ready[i];
`ifdef CDB_BYPASS_EN
      // A granted bypass goes straight to the bus and never occupies the FIFO.
      if (grant_any && (winner == 2'(i)) && !nonempty[i]) push[i] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!reset || flush) begin
        count[i]  <= 2'd0;
        wr_ptr[i] <= 1'b0;
        rd_ptr[i] <= 1'b0;
      end else begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        count[i] <= count[i] + 2'(push[i]) - 2'(pop[i]);
      end
    end
  end

  // Payload fields hold their last value when the bus is idle or flushed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb_valid    <= 1'b0;
      cdb_preg     <= '0;
      cdb_value    <= '0;
      cdb_rob      <= '0;
      cdb_regwrite <= 1'b0;
      cdb_src      <= 2'd0;
      rr_ptr       <= 2'd0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= 2'd0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      {cdb_regwrite, cdb_rob, cdb_value, cdb_preg} <= grant_ent;
      cdb_src   <= winner;
      rr_ptr    <= (winner == 2'(NUM_FU - 1)) ? 2'd0 : winner + 2'd1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter: queue-based reference model feeds a scoreboard checked by a monitor.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  fu_valid;
  logic [2:0]  fu_ready;
  logic [17:0] fu_preg_flat;
  logic [95:0] fu_value_flat;
  logic [17:0] fu_rob_flat;
  logic [2:0]  fu_regwrite;
  logic        cdb_valid;
  logic [5:0]  cdb_preg;
  logic [31:0] cdb_value;
  logic [5:0]  cdb_rob;
  logic        cdb_regwrite;
  logic [1:0]  cdb_src;

  always #5 clk = ~clk;

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_preg_flat(fu_preg_flat), .fu_value_flat(fu_value_flat),
    .fu_rob_flat(fu_rob_flat), .fu_regwrite(fu_regwrite),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_value(cdb_value),
    .cdb_rob(cdb_rob), .cdb_regwrite(cdb_regwrite), .cdb_src(cdb_src)
  );

  // Each FU holds one pending result {regwrite, rob, value, preg} until accepted.
  logic [44:0] pend_e [3];
  logic [2:0]  pend_v = 3'b000;
  logic [5:0]  rob_ctr = 6'd0;

  always_comb begin
    fu_valid      = pend_v;
    fu_preg_flat  = '0;
    fu_value_flat = '0;
    fu_rob_flat   = '0;
    fu_regwrite   = '0;
    for (int i = 0; i < 3; i++) begin
      fu_preg_flat[i*6 +: 6]   = pend_e[i][5:0];
      fu_value_flat[i*32 +: 32] = pend_e[i][37:6];
      fu_rob_flat[i*6 +: 6]    = pend_e[i][43:38];
      fu_regwrite[i]           = pend_e[i][44];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: per-FU queues of accepted results plus a round-robin start index.
  typedef struct packed {
    logic [1:0]  src;
    logic [44:0] ent;
  } bc_t;

  bc_t         exp_q[$];
  logic [44:0] mq [3][$];
  int          rr = 0;
  bit          exp_valid = 1'b0;
  logic [2:0]  exp_ready = 3'b111;
  logic [2:0]  consumed = 3'b000;
  bit          live = 1'b0;
  int          win;
  bit          byp_used;
  bit          rdy [3];
  bc_t         bc;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdy[i] = (mq[i].size() < 2);
    if (!reset) begin
      live = 1'b1;
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr = 0;
      exp_valid = 1'b0;
      consumed = 3'b000;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) begin
        consumed[i] = fu_valid[i] && rdy[i];
        mq[i].delete();
      end
      rr = 0;
      exp_valid = 1'b0;
    end else begin
      win = -1;
      byp_used = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (rr + k) % 3;
        if (win < 0 && (mq[j].size() > 0 || (BYP && fu_valid[j]))) win = j;
      end
      exp_valid = (win >= 0);
      if (win >= 0) begin
        bc.src = 2'(win);
        if (mq[win].size() > 0) bc.ent = mq[win].pop_front();
        else begin
          bc.ent = pend_e[win];
          byp_used = 1'b1;
        end
        exp_q.push_back(bc);
        rr = (win + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        consumed[i] = fu_valid[i] && rdy[i];
        if (consumed[i] && !(byp_used && win == i)) mq[i].push_back(pend_e[i]);
      end
    end
    for (int i = 0; i < 3; i++) exp_ready[i] = (mq[i].size() < 2);
  end

  // Monitor: compare bus and ready against the model between clock edges.
  bc_t got;
  always @(negedge clk) begin
    if (live) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
      chk("fu_ready", 64'(fu_ready), 64'(exp_ready));
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        if (cdb_valid) begin
          chk("cdb_src", 64'(cdb_src), 64'(got.src));
          chk("cdb_preg", 64'(cdb_preg), 64'(got.ent[5:0]));
          chk("cdb_value", 64'(cdb_value), 64'(got.ent[37:6]));
          chk("cdb_rob", 64'(cdb_rob), 64'(got.ent[43:38]));
          chk("cdb_regwrite", 64'(cdb_regwrite), 64'(got.ent[44]));
        end
      end
    end
  end

  task automatic cyc(input int p0, input int p1, input int p2, input bit fl);
    int p [3];
    p = '{p0, p1, p2};
    @(negedge clk);
    for (int i = 0; i < 3; i++) if (consumed[i]) pend_v[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!pend_v[i] && $urandom_range(99) < p[i]) begin
        pend_e[i] = {1'($urandom), rob_ctr, 32'($urandom), 6'($urandom)};
        rob_ctr++;
        pend_v[i] = 1'b1;
      end
    end
    flush = fl;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pend_e[i] = '0;
    reset = 1'b0;
    flush = 1'b0;
    // Reset held for two cycles while every FU presents.
    cyc(100, 100, 100, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_preg", 64'(cdb_preg), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_rob", 64'(cdb_rob), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_fu_ready", 64'(fu_ready), 64'd7);
    reset = 1'b1;
    repeat (12) cyc(0, 0, 0, 0);

    // Single result on FU1; latency 2 (1 with bypass).
    pend_e[1] = {1'b1, 6'd12, 32'hDEADBEEF, 6'd5};
    pend_v[1] = 1'b1;
    cyc(0, 0, 0, 0);
    chk("single_lat_first", 64'(cdb_valid), 64'(BYP));
    cyc(0, 0, 0, 0);
    chk("single_lat_second", 64'(cdb_valid), 64'(!BYP));
    chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
    chk("single_src", 64'(cdb_src), 64'd1);
    cyc(0, 0, 0, 0);
    chk("single_once", 64'(cdb_valid), 64'd0);
    repeat (4) cyc(0, 0, 0, 0);

    // Fairness and backpressure: all FUs streaming.
    repeat (9) cyc(100, 100, 100, 0);
    repeat (12) cyc(0, 0, 0, 0);

    // Flush with work pending in FU2 and FU0.
    repeat (2) cyc(100, 0, 100, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_fu_ready", 64'(fu_ready), 64'd7);
    repeat (8) cyc(0, 0, 0, 0);

    // Pointer wrap: six back-to-back results through FU0, rob 0..5.
    rob_ctr = 6'd0;
    while (rob_ctr < 6'd6) cyc(100, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 30; n++) begin
      int a, b, c;
      a = $urandom_range(100);
      b = $urandom_range(100);
      c = $urandom_range(100);
      for (int m = 0; m < 50; m++) begin
        cyc(a, b, c, ($urandom_range(63) == 0));
        reset = ($urandom_range(199) != 0);
      end
    end
    reset = 1'b1;
    repeat (20) cyc(0, 0, 0, 0);
    chk("drained_scoreboard", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
